// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the core
// data port (m0) and a secondary master (m1), routing responses by issuer.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);

    localparam logic [2:0] MASK_INIT = 3'(MEM_LATENCY);

    logic                   last;
    logic                   gnt0;
    logic                   gnt1;
    logic [MEM_LATENCY-1:0] trk_valid;
    logic [MEM_LATENCY-1:0] trk_owner;
    logic                   tail_valid;
    logic                   tail_owner;
    logic [2:0]             mask_cnt;
    logic                   err;

    // Pick one winner; contention goes to the master that was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                if (ROUND_ROBIN && !last) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign m0_gnt_o  = gnt0;
    assign m1_gnt_o  = gnt1;
    assign mem_req_o = gnt0 | gnt1;

    // Steer the granted master's fields onto the memory bus; idle bus is all zero.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_addr_o  = m0_addr_i;
            mem_we_o    = m0_we_i;
            mem_be_o    = m0_be_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_addr_o  = m1_addr_i;
            mem_we_o    = m1_we_i;
            mem_be_o    = m1_be_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    // Remember who was granted last so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (mem_req_o) begin
            last <= gnt1;
        end
    end

    // Shift {valid, owner} along with the memory so the tail lines up with rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_owner <= '0;
        end else begin
            trk_valid[0] <= mem_req_o;
            trk_owner[0] <= gnt1;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_owner[i] <= trk_owner[i-1];
            end
        end
    end

    assign tail_valid = trk_valid[MEM_LATENCY-1];
    assign tail_owner = trk_owner[MEM_LATENCY-1];

    assign m0_rvalid_o = !rst && mem_rvalid_i && tail_valid && !tail_owner;
    assign m1_rvalid_o = !rst && mem_rvalid_i && tail_valid && tail_owner;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    // Hold off the error check while responses to dropped accesses may still arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_cnt <= MASK_INIT;
        end else if (mask_cnt != 3'd0) begin
            mask_cnt <= mask_cnt - 3'd1;
        end
    end

    // Sticky flag for a response without a request or a request without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mask_cnt == 3'd0 && (mem_rvalid_i != tail_valid)) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: three configurations, random masters, a
// memory model per configuration and a scoreboard of expected responses.
module tb_data_mem_arbiter;

    typedef struct {
        int          due;
        bit          owner;
        bit          we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   mode = 0;
    bit   spur = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int cfg,
                       input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cfg%0d cycle %0d: got %h want %h",
                     name, cfg, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int L  = (g == 1) ? 2 : ((g == 2) ? 4 : 1);
        localparam bit RR = (g != 1);

        logic        m0_req = 1'b0;
        logic        m0_we = 1'b0;
        logic [31:0] m0_addr = '0;
        logic [3:0]  m0_be = '0;
        logic [31:0] m0_wdata = '0;
        logic        m1_req = 1'b0;
        logic        m1_we = 1'b0;
        logic [31:0] m1_addr = '0;
        logic [3:0]  m1_be = '0;
        logic [31:0] m1_wdata = '0;
        logic        m0_gnt;
        logic        m1_gnt;
        logic        m0_rvalid;
        logic        m1_rvalid;
        logic [31:0] m0_rdata;
        logic [31:0] m1_rdata;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
        logic        mem_rvalid = 1'b0;
        logic [31:0] mem_rdata = '0;
        logic        err;

        exp_t        q[$];
        rsp_t        pend[$];
        logic [31:0] mem[16];

        data_mem_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_LATENCY(L),
            .ROUND_ROBIN(RR)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .m0_req_i    (m0_req),
            .m0_gnt_o    (m0_gnt),
            .m0_addr_i   (m0_addr),
            .m0_we_i     (m0_we),
            .m0_be_i     (m0_be),
            .m0_wdata_i  (m0_wdata),
            .m0_rvalid_o (m0_rvalid),
            .m0_rdata_o  (m0_rdata),
            .m1_req_i    (m1_req),
            .m1_gnt_o    (m1_gnt),
            .m1_addr_i   (m1_addr),
            .m1_we_i     (m1_we),
            .m1_be_i     (m1_be),
            .m1_wdata_i  (m1_wdata),
            .m1_rvalid_o (m1_rvalid),
            .m1_rdata_o  (m1_rdata),
            .mem_req_o   (mem_req),
            .mem_addr_o  (mem_addr),
            .mem_we_o    (mem_we),
            .mem_be_o    (mem_be),
            .mem_wdata_o (mem_wdata),
            .mem_rvalid_i(mem_rvalid),
            .mem_rdata_i (mem_rdata),
            .err_o       (err)
        );

        // Memory model: capture requests from the bus, answer L cycles later.
        initial begin : mem_accept
            int   idx;
            rsp_t r;
            for (int i = 0; i < 16; i++) mem[i] = init_word(i);
            forever begin
                @(negedge clk);
                #2;
                if (mem_req === 1'b1) begin
                    idx = int'(mem_addr[5:2]);
                    r.due = cyc + L;
                    r.data = mem[idx];
                    if (mem_we) mem[idx] = merge(mem[idx], mem_wdata, mem_be);
                    pend.push_back(r);
                end
            end
        end

        initial begin : mem_answer
            forever begin
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata = '0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = pend[0].data;
                    void'(pend.pop_front());
                end else if (spur) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = 32'hBAD0_0BAD;
                end
            end
        end

        // Masters plus reference arbiter: predicts grants and pushes expected responses.
        initial begin : drive_model
            logic        r[2];
            logic        w[2];
            logic [31:0] a[2];
            logic [31:0] d[2];
            logic [3:0]  b[2];
            bit          acc[2];
            bit          last;
            logic [31:0] shadow[16];
            int          win;
            int          idx;
            exp_t        e;
            logic [71:0] want;
            logic [71:0] got;
            last = 1'b1;
            for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
            for (int m = 0; m < 2; m++) begin
                r[m] = 1'b0; w[m] = 1'b0; a[m] = '0; d[m] = '0; b[m] = '0;
                acc[m] = 1'b0;
            end
            forever begin
                @(negedge clk);
                for (int m = 0; m < 2; m++) begin
                    if (!r[m] || acc[m]) begin
                        if (mode == 3) begin
                            r[m] = 1'b1;
                            w[m] = 1'b0;
                            b[m] = 4'hF;
                            a[m] = (m == 1) ? 32'h200 : 32'h100;
                            d[m] = '0;
                        end else if (mode == 1 && $urandom_range(0, 9) < 6) begin
                            r[m] = 1'b1;
                            w[m] = 1'($urandom_range(0, 1));
                            b[m] = 4'($urandom_range(1, 15));
                            a[m] = 32'($urandom_range(0, 15) << 2);
                            d[m] = $urandom;
                        end else begin
                            r[m] = 1'b0;
                        end
                    end
                end
                m0_req = r[0]; m0_we = w[0]; m0_addr = a[0];
                m0_be = b[0]; m0_wdata = d[0];
                m1_req = r[1]; m1_we = w[1]; m1_addr = a[1];
                m1_be = b[1]; m1_wdata = d[1];
                #2;
                acc[0] = 1'b0;
                acc[1] = 1'b0;
                win = -1;
                if (rst) begin
                    last = 1'b1;
                    q.delete();
                end else if (r[0] || r[1]) begin
                    if (r[0] && r[1]) win = RR ? int'(!last) : 0;
                    else win = r[0] ? 0 : 1;
                    acc[win] = 1'b1;
                    last = (win == 1);
                    idx = int'(a[win][5:2]);
                    e.due = cyc + L;
                    e.owner = (win == 1);
                    e.we = w[win];
                    e.data = shadow[idx];
                    if (w[win]) shadow[idx] = merge(shadow[idx], d[win], b[win]);
                    q.push_back(e);
                end
                want = '0;
                if (win >= 0) want = {acc[0], acc[1], 1'b1, w[win], b[win], a[win], d[win]};
                got = {m0_gnt, m1_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata};
                chk("grant_bus", g, 128'(got), 128'(want));
            end
        end

        // Monitor: pops the scoreboard on each response and tracks the error flag.
        initial begin : monitor
            bit   exp_err;
            bit   due_now;
            int   since;
            exp_t e;
            exp_err = 1'b0;
            since = 0;
            forever begin
                @(negedge clk);
                #3;
                chk("err_o", g, 128'(err), 128'(exp_err));
                due_now = (q.size() > 0 && q[0].due == cyc);
                if (m0_rvalid || m1_rvalid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rvalid", g, 128'({m0_rvalid, m1_rvalid}), 128'(0));
                    end else begin
                        e = q.pop_front();
                        chk("rsp_owner_time", g, 128'({cyc, m0_rvalid, m1_rvalid}),
                            128'({e.due, !e.owner, e.owner}));
                        if (!e.we) begin
                            chk("rsp_data", g, 128'(e.owner ? m1_rdata : m0_rdata),
                                128'(e.data));
                        end
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    chk("missing_rvalid", g, 128'({m0_rvalid, m1_rvalid}),
                        128'({!e.owner, e.owner}));
                end
                if (rst) begin
                    exp_err = 1'b0;
                    since = 0;
                end else begin
                    since++;
                    if (since > L && (mem_rvalid != due_now)) exp_err = 1'b1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mode = 3;
        repeat (8) @(negedge clk);
        mode = 1;
        repeat (300) @(negedge clk);
        mode = 0;
        repeat (12) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (6) @(negedge clk);
        mode = 1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 3;
        repeat (8) @(negedge clk);
        mode = 1;
        repeat (100) @(negedge clk);
        mode = 0;
        repeat (12) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-master arbiter that shares the single-port data memory between the core data port (m0) and a secondary master (m1: loader/DMA/debug).
- Sits between `riscv_core` data interface plus the m1 master, and `data_mem`.
- Grants one request per cycle, round-robin or fixed-priority.
- Tracks in-flight accesses and returns each memory response to the master that issued it; flags protocol violations.

Parameters:
- ADDR_WIDTH, 32, byte-address width of master and memory address ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MEM_LATENCY, 1, cycles from accepted mem_req_o to mem_rvalid_i; legal range 1..4
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority with m0 highest

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- m0_req_i  in  1  m0 request; held with its fields until granted
- m0_gnt_o  out  1  m0 request accepted this cycle (combinational)
- m0_addr_i  in  ADDR_WIDTH  m0 byte address
- m0_we_i  in  1  m0 write enable
- m0_be_i  in  DATA_WIDTH/8  m0 byte enables
- m0_wdata_i  in  DATA_WIDTH  m0 write data
- m0_rvalid_o  out  1  response for m0
- m0_rdata_o  out  DATA_WIDTH  read data for m0
- m1_req_i, m1_gnt_o, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_rvalid_o, m1_rdata_o: same directions, widths and meanings as m0, for m1
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rvalid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  DATA_WIDTH  memory read data
- err_o  out  1  sticky protocol-error flag

Behaviour:
- **Handshake:**
  - A request is accepted in the cycle where req and gnt are both high.
  - Grant is combinational from req_i and the priority pointer, so zero-cycle accept.
  - At most one gnt is high per cycle.
- **Memory side:**
  - mem_req_o = m0_gnt_o | m1_gnt_o.
  - mem_addr/we/be/wdata are muxed from the granted master.
  - With no grant, all mem_* outputs are 0.
- **Round-robin (ROUND_ROBIN=1):**
  - The pointer `last` (1 bit) holds the id of the last granted master.
  - When both masters request, the master != last wins.
  - A single requester always wins.
  - `last` updates on every grant.
  - On reset, last = 1, so m0 wins the first contention.
- **Fixed priority (ROUND_ROBIN=0):** m0 wins whenever m0_req_i=1; `last` is unused.
- **Response tracking:**
  - Shift pipeline of MEM_LATENCY entries {valid, owner}.
  - Stage 0 loads {mem_req_o, granted id} every cycle.
  - The tail entry aligns with mem_rvalid_i.
  - The tracker has no stall: it shifts every cycle, and the memory never back-pressures.
- **Routing:**
  - mX_rvalid_o = mem_rvalid_i & tail.valid & (tail.owner == X).
  - Both mX_rdata_o are driven from mem_rdata_i. Data is only meaningful with rvalid.
- **Ordering:** responses are returned in issue order; back-to-back grants to alternating masters are legal every cycle.
- **Error detection:**
  - err_o sets on the next edge when mem_rvalid_i=1 with tail invalid, or tail valid with mem_rvalid_i=0.
  - err_o stays set until rst.
  - On an error cycle, no rvalid is forwarded for an unexpected response.
- **Reset:**
  - While rst=1: both gnt=0, mem_req_o=0, all rvalid_o=0, tracker cleared, last=1.
  - err_o reads 0 the cycle after rst is sampled high.
  - In-flight accesses at reset are dropped; their responses are never forwarded.
  - The error check is masked for the first MEM_LATENCY cycles after rst deasserts, so stale memory responses do not set err_o.
- **Latency:** master-visible response latency = MEM_LATENCY cycles after the accepting edge, with no added arbiter latency.

Test Plan:
1. MEM_LATENCY=1, reset released; m0 alone reads 0x0000_0010; memory returns 0xDEAD_BEEF.
   - m0_gnt_o=1 the same cycle; mem_addr_o=0x10, mem_we_o=0.
   - Next cycle: m0_rvalid_o=1, m0_rdata_o=0xDEAD_BEEF, m1_rvalid_o=0.
2. ROUND_ROBIN=1; m0 and m1 request continuously for 4 cycles (m0 addr 0x100, m1 addr 0x200).
   - Grants are m0, m1, m0, m1.
   - mem_addr_o sequence is 0x100, 0x200, 0x100, 0x200.
   - rvalid alternates m0, m1, m0, m1, one cycle later each.
3. ROUND_ROBIN=0; both request for 3 cycles.
   - m0_gnt_o=1 all 3 cycles; m1_gnt_o=0.
   - m1 is granted the first cycle m0_req_i drops.
4. MEM_LATENCY=2; m1 writes be=4'b0011, wdata=0x1234_5678 at 0x40, then m0 reads 0x40 the next cycle.
   - mem_be_o=0011 and mem_we_o=1 on the write.
   - m1_rvalid_o at t+2, m0_rvalid_o at t+3.
   - err_o stays 0.
5. No request outstanding; bench pulses mem_rvalid_i=1 after the mask window.
   - Neither rvalid_o asserts.
   - err_o=1 on the next edge and remains 1 until rst is asserted.
6. MEM_LATENCY=2; m0 granted, then rst asserted on the next edge.
   - All outputs 0 while rst=1; no m0_rvalid_o for the dropped access.
   - err_o=0 after release, even when the memory returns the stale response.
   - First contention after reset is granted to m0.
